// File: rtl/imm_operand_pipe.sv
// Immediate-operand decoder feeding a DEPTH-entry FIFO with valid/ready handshakes.
// Optional build macro: IMM_ZTYPE_EN enables the CSR zimm (ZTYPE) format.
module imm_operand_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:7]     In,
  input  logic [2:0]      Type,
  input  logic [3:0]      in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] Out,
  output logic [3:0]      out_tag,
  output logic            out_err,
  output logic [3:0]      count
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    RTYPE = 3'd0,
    ITYPE = 3'd1,
    STYPE = 3'd2,
    BTYPE = 3'd3,
    UTYPE = 3'd4,
    JTYPE = 3'd5,
    ZTYPE = 3'd6
  } imm_type_e;

  logic [31:0]     imm32;
  logic            dec_err;
  logic [XLEN-1:0] dec_out;

  // Every format is first built as a 32-bit value already sign-extended from
  // In[31] (zimm has bit 31 clear), so one signed widening serves both XLENs.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a latch behind.
    imm32   = '0;
    dec_err = 1'b0;
    case (Type)
      RTYPE: imm32 = '0;
      ITYPE: imm32 = {{20{In[31]}}, In[31:20]};
      STYPE: imm32 = {{20{In[31]}}, In[31:25], In[11:7]};
      BTYPE: imm32 = {{19{In[31]}}, In[31], In[7], In[30:25], In[11:8], 1'b0};
      UTYPE: imm32 = {In[31:12], 12'b0};
      JTYPE: imm32 = {{11{In[31]}}, In[31], In[19:12], In[20], In[30:21], 1'b0};
`ifdef IMM_ZTYPE_EN
      ZTYPE: imm32 = {27'b0, In[19:15]};
`else
      ZTYPE: dec_err = 1'b1;
`endif
      default: dec_err = 1'b1;
    endcase
  end

  assign dec_out = XLEN'($signed(imm32));

  logic [PW-1:0] wptr, rptr;
  logic          push, pop;

  assign in_ready  = (count != 4'(DEPTH));
  assign out_valid = (count != 4'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every register sees
    // the pre-edge values of its neighbours.
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= ptr_inc(wptr);
      if (pop)  rptr <= ptr_inc(rptr);
      case ({push, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
    end
  end

  logic [XLEN-1:0] mem_out [DEPTH];
  logic [3:0]      mem_tag [DEPTH];
  logic            mem_err [DEPTH];

  // NOTE: storage is deliberately not reset; stale entries are unreachable
  // because the head outputs are forced to zero whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_out[wptr] <= dec_out;
      mem_tag[wptr] <= in_tag;
      mem_err[wptr] <= dec_err;
    end
  end

  assign Out     = out_valid ? mem_out[rptr] : '0;
  assign out_tag = out_valid ? mem_tag[rptr] : '0;
  assign out_err = out_valid ? mem_err[rptr] : 1'b0;

endmodule

// File: tb/tb_imm_operand_pipe.sv
// Self-checking bench: XLEN=32 and XLEN=64 instances share stimulus and are
// compared each cycle against an arithmetic immediate model and a queue.
module tb_imm_operand_pipe;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:7] in_b;
  logic [2:0]  type_b;
  logic [3:0]  in_tag;

  logic        in_ready32, out_valid32, out_err32, in_ready64, out_valid64, out_err64;
  logic [31:0] out32;
  logic [63:0] out64;
  logic [3:0]  out_tag32, out_tag64, count32, count64;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  imm_operand_pipe #(.XLEN(32), .DEPTH(DEPTH)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .In(in_b), .Type(type_b), .in_tag(in_tag), .out_valid(out_valid32),
    .out_ready(out_ready), .Out(out32), .out_tag(out_tag32), .out_err(out_err32),
    .count(count32)
  );

  imm_operand_pipe #(.XLEN(64), .DEPTH(DEPTH)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .In(in_b), .Type(type_b), .in_tag(in_tag), .out_valid(out_valid64),
    .out_ready(out_ready), .Out(out64), .out_tag(out_tag64), .out_err(out_err64),
    .count(count64)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: immediates assembled from instruction fields with integer arithmetic.
  function automatic longint fld(input logic [63:0] ins, input int lo, input int n);
    return longint'((ins >> lo) & ((64'd1 << n) - 64'd1));
  endfunction

  function automatic longint sext(input longint x, input int bits);
    return (x <<< (64 - bits)) >>> (64 - bits);
  endfunction

  function automatic void ref_decode(input logic [31:7] f, input logic [2:0] ty,
                                     output longint v, output bit e);
    logic [63:0] ins;
    ins = {32'b0, f, 7'b0};
    v = 0;
    e = 1'b0;
    case (ty)
      3'd0: v = 0;
      3'd1: v = sext(fld(ins, 20, 12), 12);
      3'd2: v = sext((fld(ins, 25, 7) << 5) | fld(ins, 7, 5), 12);
      3'd3: v = sext((fld(ins, 31, 1) << 12) | (fld(ins, 7, 1) << 11) |
                     (fld(ins, 25, 6) << 5) | (fld(ins, 8, 4) << 1), 13);
      3'd4: v = sext(fld(ins, 12, 20) << 12, 32);
      3'd5: v = sext((fld(ins, 31, 1) << 20) | (fld(ins, 12, 8) << 12) |
                     (fld(ins, 20, 1) << 11) | (fld(ins, 21, 10) << 1), 21);
`ifdef IMM_ZTYPE_EN
      3'd6: v = fld(ins, 15, 5);
`else
      3'd6: e = 1'b1;
`endif
      default: e = 1'b1;
    endcase
  endfunction

  longint q_val[$];
  int     q_tag[$];
  bit     q_err[$];

  task automatic compare();
    logic [63:0] hv;
    logic [3:0]  ht;
    logic        he;
    int          sz;
    sz = q_val.size();
    hv = (sz != 0) ? q_val[0] : 64'd0;
    ht = (sz != 0) ? 4'(q_tag[0]) : 4'd0;
    he = (sz != 0) ? q_err[0] : 1'b0;
    check("count32", count32, sz);
    check("count64", count64, sz);
    check("out_valid32", out_valid32, sz != 0);
    check("out_valid64", out_valid64, sz != 0);
    check("in_ready32", in_ready32, sz != DEPTH);
    check("in_ready64", in_ready64, sz != DEPTH);
    check("out32", out32, {32'b0, hv[31:0]});
    check("out64", out64, hv);
    check("out_tag32", out_tag32, ht);
    check("out_tag64", out_tag64, ht);
    check("out_err32", out_err32, he);
    check("out_err64", out_err64, he);
  endtask

  // Apply one cycle of stimulus, advance the model across the edge, then compare.
  task automatic drive(input bit rst, input bit fl, input bit iv, input logic [31:7] f,
                       input logic [2:0] ty, input logic [3:0] tg, input bit ordy);
    longint v;
    bit     e;
    bit     do_pop, do_push;
    rst_n = ~rst; flush = fl; in_valid = iv; in_b = f; type_b = ty; in_tag = tg;
    out_ready = ordy;
    if (rst || fl) begin
      q_val.delete(); q_tag.delete(); q_err.delete();
    end else begin
      do_pop  = (q_val.size() != 0) && ordy;
      do_push = iv && (q_val.size() != DEPTH);
      if (do_pop) begin
        void'(q_val.pop_front()); void'(q_tag.pop_front()); void'(q_err.pop_front());
      end
      if (do_push) begin
        ref_decode(f, ty, v, e);
        q_val.push_back(v); q_tag.push_back(int'(tg)); q_err.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic idle(input bit ordy);
    drive(1'b0, 1'b0, 1'b0, '0, 3'd0, 4'd0, ordy);
  endtask

  initial begin
    logic [31:7] f;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_b = '0; type_b = '0; in_tag = '0;

    // Reset, with a push offered during it that must be dropped.
    drive(1'b1, 1'b0, 1'b1, '1, 3'd1, 4'hA, 1'b0);
    drive(1'b1, 1'b0, 1'b0, '0, 3'd0, 4'd0, 1'b0);
    check("rst_out64", out64, 64'd0);
    check("rst_in_ready", in_ready32, 1'b1);

    // ITYPE all-ones immediate, one-cycle latency.
    f = '0; f[31:20] = 12'hFFF;
    drive(1'b0, 1'b0, 1'b1, f, 3'd1, 4'd1, 1'b0);
    check("itype_valid", out_valid32, 1'b1);
    check("itype_out32", out32, 32'hFFFF_FFFF);
    check("itype_count", count32, 4'd1);
    idle(1'b1);

    // Fill with out_ready=0; third push is blocked, then drain in order.
    drive(1'b0, 1'b0, 1'b1, 25'h0123456, 3'd2, 4'd1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 25'h1ABCDEF, 3'd3, 4'd2, 1'b0);
    check("full_in_ready", in_ready32, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 25'h0F0F0F0, 3'd5, 4'd3, 1'b0);
    check("blocked_count", count32, 4'd2);
    check("head_tag_1", out_tag32, 4'd1);
    idle(1'b1);
    check("head_tag_2", out_tag32, 4'd2);
    idle(1'b1);
    check("drained", out_valid32, 1'b0);

    // UTYPE with bit 31 set sign-extends on XLEN=64.
    f = '0; f[31:12] = 20'h80000;
    drive(1'b0, 1'b0, 1'b1, f, 3'd4, 4'd7, 1'b0);
    check("utype_out64", out64, 64'hFFFF_FFFF_8000_0000);
    idle(1'b1);

    // Simultaneous push and pop at count=1.
    drive(1'b0, 1'b0, 1'b1, 25'h0000ABC, 3'd1, 4'd4, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 25'h1000001, 3'd2, 4'd5, 1'b1);
    check("pushpop_count", count32, 4'd1);
    check("pushpop_tag", out_tag32, 4'd5);

    // Flush at count=2 with a push in the same cycle.
    drive(1'b0, 1'b0, 1'b1, 25'h0000111, 3'd1, 4'd6, 1'b0);
    check("preflush_count", count32, 4'd2);
    drive(1'b0, 1'b1, 1'b1, 25'h0000222, 3'd1, 4'd7, 1'b0);
    check("flush_count", count32, 4'd0);
    check("flush_valid", out_valid32, 1'b0);
    idle(1'b0);
    check("flush_lost", out_valid64, 1'b0);

    // ZTYPE and the illegal code.
    f = '0; f[19:15] = 5'h1F;
    drive(1'b0, 1'b0, 1'b1, f, 3'd6, 4'd8, 1'b1);
`ifdef IMM_ZTYPE_EN
    check("ztype_out32", out32, 32'h1F);
    check("ztype_err", out_err32, 1'b0);
`else
    check("ztype_out32", out32, 32'h0);
    check("ztype_err", out_err32, 1'b1);
`endif
    drive(1'b0, 1'b0, 1'b1, '1, 3'd7, 4'd9, 1'b1);
    check("illegal_err", out_err64, 1'b1);
    check("illegal_out", out64, 64'd0);
    idle(1'b1);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(99) == 0, $urandom_range(19) == 0, $urandom_range(3) != 0,
            25'($urandom), 3'($urandom), 4'($urandom), $urandom_range(2) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_operand_pipe.md
IMM_OPERAND_PIPE -- requirements
Module: imm_operand_pipe

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, operand width; legal values are 32 and 64.
REQ-002 The block SHALL have parameter DEPTH, default 2, output queue entries; legal values are 2, 4 and 8.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port flush, input, 1 bit: discards all queued entries.
REQ-006 The block SHALL have port in_valid, input, 1 bit: upstream offers an instruction.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block can accept an instruction.
REQ-008 The block SHALL have port In, input, 25 bits [31:7]: instruction bits without the opcode.
REQ-009 The block SHALL have port Type, input, 3 bits: immediate format code.
REQ-010 The block SHALL have port in_tag, input, 4 bits: opaque ID carried with the instruction.
REQ-011 The block SHALL have port out_valid, output, 1 bit: the queue head is valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit: downstream consumes the head.
REQ-013 The block SHALL have port Out, output, XLEN bits: the immediate at the queue head.
REQ-014 The block SHALL have port out_tag, output, 4 bits: the tag of the queue head.
REQ-015 The block SHALL have port out_err, output, 1 bit: the head carried an illegal Type.
REQ-016 The block SHALL have port count, output, 4 bits: queue occupancy, 0..DEPTH.

Function
REQ-017 Type codes SHALL be: RTYPE 0, ITYPE 1, STYPE 2, BTYPE 3, UTYPE 4, JTYPE 5, ZTYPE 6; code 7 is illegal.
REQ-018 Bit layouts SHALL be RV32I: I {In[31:20]}; S {In[31:25],In[11:7]}; B {In[31],In[7],In[30:25],In[11:8],0}; U {In[31:12],12'b0}; J {In[31],In[19:12],In[20],In[30:21],0}.
REQ-019 I, S, B and J results SHALL be sign-extended from In[31] to XLEN; the U result SHALL be sign-extended from bit 31 when XLEN=64.
REQ-020 RTYPE SHALL produce 0 with out_err=0.
REQ-021 Illegal Type (including ZTYPE when it is compiled out) SHALL produce Out=0 with out_err=1; it is never X.
REQ-022 An instruction SHALL be accepted when in_valid and in_ready are both 1; the decoded Out, tag and err are written into the queue tail in that cycle.
REQ-023 in_ready SHALL be (count != DEPTH); it has no combinational path from out_ready, so there is no push when full even if a pop occurs in the same cycle.
REQ-024 Latency SHALL be one cycle: an entry accepted in cycle N is visible at the head with out_valid=1 in cycle N+1 if the queue was empty.
REQ-025 out_valid SHALL be (count != 0); a pop occurs when out_valid and out_ready are both 1.
REQ-026 Out, out_tag and out_err SHALL be stable while out_valid=1 and out_ready=0.
REQ-027 A simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged and preserve order.
REQ-028 Read and write pointers SHALL wrap modulo DEPTH; entries are delivered in strict FIFO order.
REQ-029 flush=1 SHALL set count=0 and both pointers to 0 on the next edge; a push or pop in the same cycle is discarded, and out_valid=0 in the next cycle.
REQ-030 A pop SHALL be ignored when out_valid=0.

Reset
REQ-031 When rst_n=0 at a clock edge, the block SHALL set count=0, pointers=0, out_valid=0, in_ready=1, Out=0, out_tag=0 and out_err=0.
REQ-032 Reset SHALL take priority over flush, push and pop; an entry in flight is lost.
REQ-033 Queue storage SHALL not require reset, but the head outputs SHALL read 0 while count=0.

Configuration
REQ-034 Macro IMM_ZTYPE_EN, when defined, SHALL enable ZTYPE: Out = zero-extended In[19:15] (CSR zimm) with out_err=0.
REQ-035 When IMM_ZTYPE_EN is undefined, ZTYPE SHALL be treated as illegal per REQ-021, and no other behaviour SHALL change.

Verification
REQ-036 Bench SHALL cover: reset, then push ITYPE In[31:20]=12'hFFF, XLEN=32 -> next cycle out_valid=1, Out=32'hFFFFFFFF, count=1.
REQ-037 Bench SHALL cover: DEPTH=2, out_ready=0, push three items -> third blocked (in_ready=0 after two); then out_ready=1 -> tags delivered in order, each once.
REQ-038 Bench SHALL cover: XLEN=64, UTYPE In[31:12]=20'h80000 -> Out=64'hFFFFFFFF80000000.
REQ-039 Bench SHALL cover: count=1, simultaneous push and pop -> count stays 1 and the new tag is at the head next cycle.
REQ-040 Bench SHALL cover: count=2 with flush=1 and in_valid=1 in the same cycle -> next cycle count=0, out_valid=0, the pushed item is lost.
REQ-041 Bench SHALL cover: Type=6 with In[19:15]=5'h1F -> Out=32'h1F with out_err=0 when IMM_ZTYPE_EN is defined; Out=0 with out_err=1 when it is undefined. Type=7 -> out_err=1 in both builds.
